// File: rtl/tick_gen_pkg.sv
// Shared constants, lock-state encoding and increment helper for the NCO tick bank.
// Optional build macro: TICK_GEN_PHASE_EN (programmable per-channel sync phase).
package tick_gen_pkg;

  localparam int          ACC_W_DEF       = 32;
  // 1 MHz at 50 MHz refclk with a 32-bit accumulator, rounded to nearest
  localparam logic [31:0] INC_DEFAULT_DEF = 32'h051E_B852;
  localparam int          LOCK_CYCLES_DEF = 1024;
  localparam int          CH_IDX_W        = 3;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Increment for a target tick rate: round(f_out * 2^acc_w / f_ref)
  function automatic logic [63:0] calc_inc(input longint unsigned f_out,
                                           input longint unsigned f_ref,
                                           input int              acc_w);
    logic [63:0] num;
    num = (64'(f_out) << acc_w) + (f_ref >> 1);
    return num / f_ref;
  endfunction

endpackage

// File: rtl/tick_gen_nco.sv
// One NCO channel: phase accumulator, increment register, registered tick and
// divided square wave. With TICK_GEN_PHASE_EN, a phase register sets the
// accumulator value loaded on sync.
module tick_gen_nco
  import tick_gen_pkg::*;
#(
  parameter int               ACC_W   = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_RST = ACC_W'(INC_DEFAULT_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             inc_we_i,
`ifdef TICK_GEN_PHASE_EN
  input  logic             phase_we_i,
`endif
  input  logic [ACC_W-1:0] wdata_i,
  output logic             tick_o,
  output logic             outclk_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q;
  logic             tick_q, tick_d;
  logic             outclk_q, outclk_d;
  logic [ACC_W-1:0] sync_val;
  logic [ACC_W:0]   sum;

`ifdef TICK_GEN_PHASE_EN
  logic [ACC_W-1:0] phase_q;

  // Phase offset register, loaded into the accumulator on sync
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         phase_q <= '0;
    else if (phase_we_i) phase_q <= wdata_i;
  end

  assign sync_val = phase_q;
`else
  assign sync_val = '0;
`endif

  // Carry out of the ACC_W+1-bit sum is the overflow tick
  assign sum = {1'b0, acc_q} + {1'b0, inc_q};

  // Next state: sync beats enable; disabled channel holds acc, forces outputs low
  always_comb begin
    acc_d    = acc_q;
    tick_d   = 1'b0;
    outclk_d = outclk_q;
    if (sync_i) begin
      acc_d    = sync_val;
      outclk_d = 1'b0;
    end else if (!en_i) begin
      outclk_d = 1'b0;
    end else begin
      acc_d    = sum[ACC_W-1:0];
      tick_d   = sum[ACC_W];
      outclk_d = outclk_q ^ sum[ACC_W];
    end
  end

  // Accumulator and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      tick_q   <= 1'b0;
      outclk_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      tick_q   <= tick_d;
      outclk_q <= outclk_d;
    end
  end

  // Increment register; a new value is used from the following add
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       inc_q <= INC_RST;
    else if (inc_we_i) inc_q <= wdata_i;
  end

  assign tick_o   = tick_q;
  assign outclk_o = outclk_q;

endmodule

// File: rtl/tick_gen_nco_bank.sv
// Bank of N_CH reprogrammable NCO tick generators sharing refclk, with write
// decode and a settle/lock FSM. Optional build macro: TICK_GEN_PHASE_EN adds
// the wr_phase port selecting per-channel phase writes.
module tick_gen_nco_bank
  import tick_gen_pkg::*;
#(
  parameter int               N_CH        = 2,
  parameter int               ACC_W       = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_DEFAULT = ACC_W'(INC_DEFAULT_DEF),
  parameter int               LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                sync,
  input  logic                wr_en,
  input  logic [CH_IDX_W-1:0] wr_ch,
  input  logic [ACC_W-1:0]    wr_data,
`ifdef TICK_GEN_PHASE_EN
  input  logic                wr_phase,
`endif
  output logic [N_CH-1:0]     tick,
  output logic [N_CH-1:0]     outclk,
  output logic                locked
);

  localparam int              CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  logic            wr_valid;
  logic            sel_phase;
  logic            disturb;
  logic [N_CH-1:0] inc_we;
  logic [N_CH-1:0] phase_we;

  // Out-of-range channel writes are dropped and do not disturb lock
  assign wr_valid = wr_en && (int'(wr_ch) < N_CH);
`ifdef TICK_GEN_PHASE_EN
  assign sel_phase = wr_phase;
`else
  assign sel_phase = 1'b0;
`endif
  assign disturb = wr_valid || sync;

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    assign inc_we[i]   = wr_valid && (wr_ch == CH_IDX_W'(i)) && !sel_phase;
    assign phase_we[i] = wr_valid && (wr_ch == CH_IDX_W'(i)) &&  sel_phase;

    tick_gen_nco #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_DEFAULT)
    ) u_nco (
      .clk_i      (refclk),
      .rst_ni     (rst),
      .en_i       (ch_en[i]),
      .sync_i     (sync),
      .inc_we_i   (inc_we[i]),
`ifdef TICK_GEN_PHASE_EN
      .phase_we_i (phase_we[i]),
`endif
      .wdata_i    (wr_data),
      .tick_o     (tick[i]),
      .outclk_o   (outclk[i])
    );
  end

`ifndef TICK_GEN_PHASE_EN
  // Phase strobes only feed channels when the phase feature is built in
  logic unused_phase;
  assign unused_phase = ^phase_we;
`endif

  lock_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            locked_q, locked_d;

  // Lock FSM state, settle counter and registered locked flag
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q  <= UNLOCKED;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  // Count undisturbed cycles (saturating); any retune or sync restarts the settle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    locked_d = locked_q;
    case (state_q)
      UNLOCKED: begin
        locked_d = 1'b0;
        if (disturb) begin
          cnt_d = '0;
        end else begin
          if (cnt_q != LOCK_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == LOCK_MAX) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (disturb) begin
          state_d  = UNLOCKED;
          cnt_d    = '0;
          locked_d = 1'b0;
        end
      end
      default: begin
        state_d  = UNLOCKED;
        cnt_d    = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  assign locked = locked_q;

endmodule

// File: tb/tb_tick_gen_nco_bank.sv
// Directed bench for tick_gen_nco_bank: an 8-bit, 2-channel bank with short
// lock time driven from a vector table plus hand sequences, and a default
// 32-bit single-channel bank checked for the 1 MHz tick rate.
module tb_tick_gen_nco_bank;

  logic       refclk = 1'b0;
  always #5 refclk = ~refclk;

  // 8-bit bank
  logic       rst;
  logic [1:0] ch_en;
  logic       sync;
  logic       wr_en;
  logic [2:0] wr_ch;
  logic [7:0] wr_data;
  logic [1:0] tick;
  logic [1:0] outclk;
  logic       locked;

  // 32-bit default bank
  logic        rst32;
  logic [0:0]  ch_en32;
  logic        sync32;
  logic        wr_en32;
  logic [2:0]  wr_ch32;
  logic [31:0] wr_data32;
  logic [0:0]  tick32;
  logic [0:0]  outclk32;
  logic        locked32;

`ifdef TICK_GEN_PHASE_EN
  logic wr_phase   = 1'b0;
  logic wr_phase32 = 1'b0;
`endif

  tick_gen_nco_bank #(
    .N_CH        (2),
    .ACC_W       (8),
    .INC_DEFAULT (8'd16),
    .LOCK_CYCLES (16)
  ) u_dut (
    .refclk  (refclk),
    .rst     (rst),
    .ch_en   (ch_en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_data (wr_data),
`ifdef TICK_GEN_PHASE_EN
    .wr_phase(wr_phase),
`endif
    .tick    (tick),
    .outclk  (outclk),
    .locked  (locked)
  );

  tick_gen_nco_bank #(
    .N_CH (1)
  ) u_dut32 (
    .refclk  (refclk),
    .rst     (rst32),
    .ch_en   (ch_en32),
    .sync    (sync32),
    .wr_en   (wr_en32),
    .wr_ch   (wr_ch32),
    .wr_data (wr_data32),
`ifdef TICK_GEN_PHASE_EN
    .wr_phase(wr_phase32),
`endif
    .tick    (tick32),
    .outclk  (outclk32),
    .locked  (locked32)
  );

  typedef struct {
    logic [1:0] en;
    logic       sy;
    logic       wr;
    logic [2:0] ch;
    logic [7:0] data;
    logic [1:0] tick;
    logic [1:0] oclk;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // n identical rows
  function automatic void addv(input int n, input logic [1:0] en, input logic sy,
                               input logic wr, input logic [2:0] ch, input logic [7:0] d,
                               input logic [1:0] t, input logic [1:0] o);
    vec_t v;
    v = '{en, sy, wr, ch, d, t, o};
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic step;
    @(posedge refclk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic found;

    rst = 1'b0; ch_en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    rst32 = 1'b0; ch_en32 = '0; sync32 = 1'b0; wr_en32 = 1'b0; wr_ch32 = '0; wr_data32 = '0;

    // ---- vector table: {ch_en, sync, wr_en, wr_ch, wr_data} -> {tick, outclk}
    addv(1, 2'b00, 0, 1, 3'd0, 8'd64,  2'b00, 2'b00); // inc0 = 64
    addv(3, 2'b01, 0, 0, 3'd0, 8'd0,   2'b00, 2'b00);
    addv(1, 2'b01, 0, 0, 3'd0, 8'd0,   2'b01, 2'b01); // first tick 4 cycles in
    addv(3, 2'b01, 0, 0, 3'd0, 8'd0,   2'b00, 2'b01);
    addv(1, 2'b01, 0, 0, 3'd0, 8'd0,   2'b01, 2'b00);
    addv(3, 2'b01, 0, 0, 3'd0, 8'd0,   2'b00, 2'b00);
    addv(1, 2'b01, 0, 0, 3'd0, 8'd0,   2'b01, 2'b01);
    addv(1, 2'b00, 0, 0, 3'd0, 8'd0,   2'b00, 2'b00); // disable forces outclk low
    addv(3, 2'b01, 0, 0, 3'd0, 8'd0,   2'b00, 2'b00); // resume from held acc
    addv(1, 2'b01, 0, 0, 3'd0, 8'd0,   2'b01, 2'b01);
    addv(1, 2'b01, 0, 1, 3'd1, 8'd32,  2'b00, 2'b01); // inc1 = 32
    addv(1, 2'b11, 0, 0, 3'd0, 8'd0,   2'b00, 2'b01);
    addv(1, 2'b11, 1, 0, 3'd0, 8'd0,   2'b00, 2'b00); // sync
    addv(3, 2'b11, 0, 0, 3'd0, 8'd0,   2'b00, 2'b00);
    addv(1, 2'b11, 0, 0, 3'd0, 8'd0,   2'b01, 2'b01); // ch0 +4
    addv(3, 2'b11, 0, 0, 3'd0, 8'd0,   2'b00, 2'b01);
    addv(1, 2'b11, 0, 0, 3'd0, 8'd0,   2'b11, 2'b10); // ch0 and ch1 +8
    addv(1, 2'b11, 0, 1, 3'd0, 8'd0,   2'b00, 2'b10); // inc0 = 0
    addv(6, 2'b11, 0, 0, 3'd0, 8'd0,   2'b00, 2'b10);
    addv(1, 2'b11, 0, 0, 3'd0, 8'd0,   2'b10, 2'b00); // only ch1 ticks
    addv(1, 2'b11, 1, 1, 3'd0, 8'd128, 2'b00, 2'b00); // sync + write together
    addv(1, 2'b11, 0, 1, 3'd5, 8'd255, 2'b00, 2'b00); // out-of-range write
    addv(1, 2'b11, 0, 0, 3'd0, 8'd0,   2'b01, 2'b01);

    // ---- reset state
    #12;
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset outclk", 32'(outclk), 32'd0);
    chk("reset locked", 32'(locked), 32'd0);

    // ---- lock sequence (release mid-cycle; edge k after release = cycle k)
    @(posedge refclk); #3; rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step;
      if (k == 15) chk("lock c15", 32'(locked), 32'd0);
      if (k == 16) chk("lock c16", 32'(locked), 32'd1);
    end
    wr_en = 1'b1; wr_ch = 3'd0; wr_data = 8'd64;
    step; // cycle 21
    wr_en = 1'b0;
    chk("lock drop c21", 32'(locked), 32'd0);
    for (int k = 22; k <= 37; k++) begin
      step;
      if (k == 36) chk("lock c36", 32'(locked), 32'd0);
      if (k == 37) chk("lock c37", 32'(locked), 32'd1);
    end
    wr_en = 1'b1; wr_ch = 3'd5; wr_data = 8'd255;
    step;
    wr_en = 1'b0;
    chk("lock bad ch", 32'(locked), 32'd1);
    sync = 1'b1;
    step;
    sync = 1'b0;
    chk("lock sync drop", 32'(locked), 32'd0);

    // ---- table vectors from a fresh reset
    rst = 1'b0; #2; rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      ch_en = tbl[i].en; sync = tbl[i].sy; wr_en = tbl[i].wr;
      wr_ch = tbl[i].ch; wr_data = tbl[i].data;
      step;
      chk($sformatf("vec%0d tick", i), 32'(tick), 32'(tbl[i].tick));
      chk($sformatf("vec%0d outclk", i), 32'(outclk), 32'(tbl[i].oclk));
    end
    sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;

    // ---- async reset while ticking and locked
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step;
      found = locked;
    end
    chk("relock before async rst", 32'(found), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      step;
      found = tick[0] && outclk[0];
    end
    chk("tick+outclk high before rst", 32'(found), 32'd1);
    #2; rst = 1'b0; #1;
    chk("async rst tick", 32'(tick), 32'd0);
    chk("async rst outclk", 32'(outclk), 32'd0);
    chk("async rst locked", 32'(locked), 32'd0);
    ch_en = 2'b01;
    #1; rst = 1'b1;
    n = 0;
    for (int k = 1; k <= 16; k++) begin
      step;
      if (k < 16) n += int'(tick != 2'b00);
      else chk("default inc tick @16", 32'(tick), 32'd1);
    end
    chk("default inc no early tick", 32'(n), 32'd0);
    ch_en = 2'b00;

    // ---- 32-bit default bank: 50000 cycles at 1 MHz equivalent
    #2; rst32 = 1'b1; ch_en32 = 1'b1;
    n = 0;
    for (int k = 0; k < 50000; k++) begin
      step;
      n += int'(tick32);
    end
    checks++;
    if (n < 999 || n > 1001) begin
      errors++;
      $display("FAIL nco32 tick count: got %0d expected 1000 +/-1", n);
    end
    chk("nco32 locked", 32'(locked32), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_gen_nco_bank.md
Name: tick_gen_nco_bank

Overview:
Parametrised, run-time reprogrammable successor to the fixed two-output clock generator in the ECG front end.
- Generates N_CH independent clock-enable ticks and divided square-wave clocks from `refclk`, one phase-accumulator NCO per channel.
- Downstream ADC-sample, filter and UART logic consume the ticks as clock enables in the single `refclk` domain.
- Sample rates can be retuned at run time without rebuilding a PLL; a `locked` flag tells consumers when outputs are settled.

Parameters:
N_CH, 2, number of NCO channels (1..8)
ACC_W, 32, accumulator width in bits
INC_DEFAULT, 32'h051E_B852, reset increment for every channel (1 MHz tick at 50 MHz refclk, ACC_W=32)
LOCK_CYCLES, 1024, settle cycles before `locked` asserts (>=1)

Ports:
refclk  in  1  system clock, 50 MHz nominal
rst  in  1  asynchronous active-low reset
ch_en  in  N_CH  per-channel run enable
sync  in  1  one-cycle pulse; realigns all channels
wr_en  in  1  increment write strobe
wr_ch  in  3  channel index for write
wr_data  in  ACC_W  new increment value
tick  out  N_CH  one-refclk-cycle pulse per accumulator overflow
outclk  out  N_CH  square wave, toggles on each tick
locked  out  1  outputs stable for LOCK_CYCLES cycles

Behaviour:
- Reset (rst=0, asynchronous): acc=0, inc=INC_DEFAULT, tick=0, outclk=0, locked=0, settle counter=0.
- Per cycle, channel running (ch_en[i]=1, sync=0): {carry, acc} <= acc + inc, computed as an ACC_W+1-bit sum; tick[i] <= carry.
- Tick latency: tick is registered, so it appears the cycle after the overflowing add.
- Tick rate = f_refclk*inc/2^ACC_W; outclk rate is half the tick rate.
- outclk[i] toggles in the same cycle tick[i]=1.
- inc=0: accumulator holds, no ticks, outclk holds its level.
- ch_en[i]=0: acc holds, tick[i]=0, outclk[i] forced 0. Re-enable resumes from the held acc.
- sync=1: every acc loads its phase value (0 unless optional feature enabled), all outclk<=0, all tick<=0 that cycle. sync overrides ch_en.
- Write with wr_en=1 and wr_ch<N_CH: inc[wr_ch] updates next cycle. acc is not cleared; the new inc is used from the following add.
- Write with wr_ch>=N_CH: ignored entirely, no lock effect.
- sync and a write in the same cycle: both take effect.
- Lock FSM, two states:
  - UNLOCKED: counter increments each cycle; on reaching LOCK_CYCLES, go to LOCKED, locked<=1.
  - LOCKED: any valid write or sync returns to UNLOCKED, counter<=0, locked<=0 on the next edge.
  - Counter saturates; it never wraps.
- locked does not depend on ch_en.

Optional Feature:
TICK_GEN_PHASE_EN
- Defined: a second write target is selected by extra input `wr_phase` (1 bit). When wr_phase=1, wr_data writes phase[wr_ch] instead of inc. sync loads acc<=phase[i], giving programmable inter-channel phase offset. Reset value of phase is 0. Phase writes also drop locked.
- Undefined: no `wr_phase` port and no phase registers; sync loads 0.

Decomposition:
- Package tick_gen_pkg: ACC_W default, INC_DEFAULT, LOCK_CYCLES default, lock state enum {UNLOCKED, LOCKED}, constant function computing inc from f_out/f_ref.
- Sub-module tick_gen_nco: one channel containing acc, inc, (phase), tick and outclk registers.
- Top level: generate loop over N_CH instances, write decode, and the lock FSM.

Test Plan:
- ACC_W=8, reset release, write inc=64 to ch0, ch_en=01 -> ch0 ticks every 4 cycles, first tick 4 cycles after enable; outclk0 period 8 cycles; ch1 silent.
- inc=0x51EB852, ACC_W=32, run 50 000 cycles -> exactly 1000 ticks +/-1 (1 MHz equivalent).
- LOCK_CYCLES=16: locked rises at cycle 16 after reset; write inc at cycle 20 -> locked low at 21, high again at 37; write with wr_ch=5 -> locked unaffected.
- ACC_W=8, ch0 inc=64, ch1 inc=32, pulse sync mid-run -> both acc=0, outclk=00; next ticks at +4 and +8 cycles.
- Assert rst=0 asynchronously between clock edges while ticking -> tick, outclk and locked drop immediately; inc returns to INC_DEFAULT.
- TICK_GEN_PHASE_EN: ACC_W=8, inc=64 both, phase1=128, sync -> ch1 ticks 2 cycles before ch0, then steady 2-cycle offset.
